// File: rtl/cpu_defs.sv
// ============================================================================
// cpu_defs : shared CPU types for the instruction-fetch front end
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_defs;

    typedef logic [31:0] virt_t;

    typedef struct packed {
        virt_t       pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_WAIT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/cpu_ibus_if.sv
// ============================================================================
// cpu_ibus_if : instruction bus, one-cycle pipelined slave with stall
// Rev 1.0
// ============================================================================
`default_nettype none

interface cpu_ibus_if;
    import cpu_defs::*;

    logic        read;
    virt_t       address;
    logic        stall;
    logic [63:0] rddata;

    modport master (output read, output address, input stall, input rddata);
    modport slave  (input read, input address, output stall, output rddata);

endinterface

`default_nettype wire

// File: rtl/ifetch_instr_fifo.sv
// ============================================================================
// ifetch_instr_fifo : circular buffer, two pushes / one pop per cycle, flush
// Rev 1.0
// ============================================================================
`default_nettype none

module ifetch_instr_fifo
    import cpu_defs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  fetch_entry_t               i_push_lo,
    input  fetch_entry_t               i_push_hi,
    input  logic                       i_pop,
    output logic                       o_valid,
    output fetch_entry_t               o_head,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_pop;

    // Popping an empty buffer is ignored rather than corrupting the pointers.
    assign w_pop = i_pop && (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(2);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (i_push ? CW'(2) : CW'(0)) - (w_pop ? CW'(1) : CW'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr]          <= i_push_lo;
            r_mem[r_wr_ptr + AW'(1)] <= i_push_hi;
        end
    end

    assign o_valid = (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/ifetch_ibus_master.sv
// ============================================================================
// ifetch_ibus_master : instruction-fetch bus master, 64-bit fetches into FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module ifetch_ibus_master
    import cpu_defs::*;
#(
    parameter virt_t RESET_PC   = 32'hbfc0_0000,
    parameter int    FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    cpu_ibus_if.master  ibus,
    input  logic        redirect_valid,
    input  virt_t       redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output virt_t       instr_pc,
    output logic [31:0] instr_data
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int LW = CW + 1;

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic          r_active;
    logic          r_discard;
    virt_t         r_fetch_pc;
    virt_t         r_req_pc;

    logic          w_resp;
    logic          w_push;
    logic          w_pop;
    logic          w_issue;
    logic          w_read;
    virt_t         w_address;
    logic [CW-1:0] w_count;
    logic [LW-1:0] w_level_nxt;
    fetch_entry_t  w_lo;
    fetch_entry_t  w_hi;
    fetch_entry_t  w_head;

    assign w_resp = (r_state == c_ST_WAIT) && !ibus.stall;
    assign w_push = w_resp && !r_discard && !redirect_valid;
    assign w_pop  = instr_ready && instr_valid && !redirect_valid;

    // Only issue when both words of the response are guaranteed a slot.
    assign w_level_nxt = LW'(w_count) + (w_push ? LW'(2) : LW'(0)) - (w_pop ? LW'(1) : LW'(0));
    assign w_issue     = r_active && !redirect_valid
                      && ((r_state == c_ST_IDLE) || w_resp)
                      && (w_level_nxt <= LW'(FIFO_DEPTH - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_issue) w_state_nxt = c_ST_WAIT;
            c_ST_WAIT: if (!ibus.stall) w_state_nxt = w_issue ? c_ST_WAIT : c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // A stalled request is re-presented unchanged, even across a redirect.
    always_comb begin
        w_read    = ((r_state == c_ST_WAIT) && ibus.stall) || w_issue;
        w_address = w_issue ? r_fetch_pc : r_req_pc;
    end

    assign ibus.read    = w_read;
    assign ibus.address = w_address;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active   <= 1'b0;
            r_discard  <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
        end else begin
            r_active <= 1'b1;
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd8;
            end
            if (w_issue) begin
                r_req_pc <= r_fetch_pc;
            end
            if (redirect_valid && (r_state == c_ST_WAIT) && ibus.stall) begin
                r_discard <= 1'b1;
            end else if (w_resp) begin
                r_discard <= 1'b0;
            end
        end
    end

    assign w_lo = {r_req_pc, ibus.rddata[31:0]};
    assign w_hi = {r_req_pc + 32'd4, ibus.rddata[63:32]};

    ifetch_instr_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (redirect_valid),
        .i_push    (w_push),
        .i_push_lo (w_lo),
        .i_push_hi (w_hi),
        .i_pop     (w_pop),
        .o_valid   (instr_valid),
        .o_head    (w_head),
        .o_count   (w_count)
    );

    assign instr_pc   = w_head.pc;
    assign instr_data = w_head.instr;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_ibus_master.sv
// ============================================================================
// tb_ifetch_ibus_master : randomized bench for ifetch_ibus_master
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ifetch_ibus_master;
    import cpu_defs::*;

    localparam virt_t c_RESET_PC = 32'hbfc0_0000;
    localparam int    c_DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid;
    virt_t       redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    virt_t       instr_pc;
    logic [31:0] instr_data;

    always #5 clk = ~clk;

    cpu_ibus_if ibus_if ();

    ifetch_ibus_master #(
        .RESET_PC       (c_RESET_PC),
        .FIFO_DEPTH     (c_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ibus           (ibus_if),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_pc       (instr_pc),
        .instr_data     (instr_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: FIFO occupancy, one outstanding request, expected streams.
    int    occ;
    bit    p_valid;
    bit    p_stale;
    bit    booting;
    virt_t p_addr;
    virt_t exp_pc;
    virt_t exp_fetch;
    int    stall_pct;
    int    ready_pct;
    int    redir_pct;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memw(input virt_t a);
        return (a - c_RESET_PC) >> 2;
    endfunction

    task automatic model_reset();
        occ       = 0;
        p_valid   = 1'b0;
        p_stale   = 1'b0;
        booting   = 1'b1;
        exp_pc    = c_RESET_PC;
        exp_fetch = c_RESET_PC;
    endtask

    // One clock cycle, entered and left at posedge+1.
    task automatic step();
        bit    st, rd, rv, resp, held, pop, exp_issue;
        int    lvl;
        virt_t rp;
        st = p_valid && ($urandom_range(99) < stall_pct);
        rd = ($urandom_range(99) < ready_pct);
        rv = !booting && ($urandom_range(99) < redir_pct);
        case ($urandom_range(3))
            0:       rp = 32'h8000_0100;
            1:       rp = 32'hffff_fff8;
            default: rp = $urandom & 32'hffff_fffc;
        endcase
        ibus_if.stall  = st;
        instr_ready    = rd;
        redirect_valid = rv;
        redirect_pc    = rp;
        ibus_if.rddata = (p_valid && !st) ? {memw(p_addr + 32'd4), memw(p_addr)}
                                          : {$urandom, $urandom};
        @(negedge clk);
        resp      = p_valid && !st;
        held      = p_valid && st;
        pop       = rd && !rv && (occ != 0);
        lvl       = occ + ((resp && !p_stale && !rv) ? 2 : 0) - (pop ? 1 : 0);
        exp_issue = !booting && !rv && !held && (lvl <= c_DEPTH - 2);
        check("instr_valid", instr_valid, occ != 0);
        check("read", ibus_if.read, held || exp_issue);
        if (held)
            check("held_addr", ibus_if.address, p_addr);
        else if (exp_issue)
            check("issue_addr", ibus_if.address, exp_fetch);
        if (pop) begin
            check("instr_pc", instr_pc, exp_pc);
            check("instr_data", instr_data, memw(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
        booting = 1'b0;
        if (rv) begin
            occ       = 0;
            exp_pc    = rp;
            exp_fetch = rp;
            if (held) begin
                p_stale = 1'b1;
            end else begin
                p_valid = 1'b0;
                p_stale = 1'b0;
            end
        end else begin
            if (resp && !p_stale) occ = occ + 2;
            if (pop) occ = occ - 1;
            if (resp) begin
                p_valid = 1'b0;
                p_stale = 1'b0;
            end
            if (exp_issue) begin
                p_valid   = 1'b1;
                p_addr    = exp_fetch;
                exp_fetch = exp_fetch + 32'd8;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input int s, input int r, input int d);
        stall_pct = s;
        ready_pct = r;
        redir_pct = d;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        ibus_if.stall  = 1'b0;
        ibus_if.rddata = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_read", ibus_if.read, 1'b0);
        check("rst_addr", ibus_if.address, c_RESET_PC);
        check("rst_valid", instr_valid, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run(100, 0, 100, 0);
        run(12, 0, 0, 0);
        check("full_valid", instr_valid, 1'b1);
        check("full_read", ibus_if.read, 1'b0);
        run(30, 0, 100, 0);
        run(600, 40, 70, 0);
        run(1500, 40, 70, 6);

        // Asynchronous reset in the middle of traffic.
        ibus_if.stall = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_read", ibus_if.read, 1'b0);
        check("arst_valid", instr_valid, 1'b0);
        ibus_if.stall  = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        run(400, 30, 80, 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=%0d exp=%0d", 0, 1);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
